// File: rtl/hdlc_tx_scheduler.sv
// Arbitrates two byte-stream requesters onto one HDLC transmitter: loads the TX
// buffer, enables transmission, polls Tx_Done, and handles abort and oversize frames.
module hdlc_tx_scheduler #(
  parameter int MAX_BYTES = 126,
  parameter int POLL_GAP  = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Req_Valid,
  input  logic [15:0] Req_Data,
  input  logic [1:0]  Req_Last,
  input  logic [1:0]  Req_Abort,
  output logic [1:0]  Req_Ready,
  output logic [1:0]  Req_Done,
  output logic [1:0]  Req_Err,
  output logic        Grant,
  output logic        Busy,
  output logic [2:0]  Address,
  output logic        WriteEnable,
  output logic        ReadEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut
);

  localparam logic [2:0] ADDR_TX_SC     = 3'd0;
  localparam logic [2:0] ADDR_TX_BUFF   = 3'd1;
  localparam logic [7:0] TX_ENABLE      = 8'h02;
  localparam logic [7:0] TX_ABORT_FRAME = 8'h04;
  localparam logic [7:0] MAX_CNT        = 8'(MAX_BYTES);
  localparam logic [7:0] GAP_LAST       = 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, START, GAP, POLL, CHECK, ABORT, DRAIN, FINISH
  } state_t;

  state_t      state_r;
  state_t      next_s;
  logic        grant_r;
  logic        lastServed_r;
  logic        oversize_r;
  logic        busy_r;
  logic [7:0]  byteCnt_r;
  logic [7:0]  gapCnt_r;
  logic [1:0]  done_r;
  logic [1:0]  err_r;

  logic        abortG_s;
  logic        validG_s;
  logic        lastG_s;
  logic [7:0]  byteG_s;
  logic [1:0]  grantOneHot_s;
  logic [7:0]  cntNext_s;
  logic [1:0]  ready_s;
  logic        wrEn_s;
  logic        rdEn_s;
  logic [2:0]  addr_s;
  logic [7:0]  din_s;
  logic        accept_s;
  logic        setOversize_s;
  logic        finishOk_s;
  logic        unusedStatus_s;

  assign abortG_s       = Req_Abort[grant_r];
  assign validG_s       = Req_Valid[grant_r];
  assign lastG_s        = Req_Last[grant_r];
  assign byteG_s        = grant_r ? Req_Data[15:8] : Req_Data[7:0];
  assign grantOneHot_s  = grant_r ? 2'b10 : 2'b01;
  assign cntNext_s      = byteCnt_r + 8'd1;
  // Only Tx_Done matters for scheduling; the other status bits are informational.
  assign unusedStatus_s = ^DataOut[7:1];

  // Next-state and same-cycle handshake / HDLC bus decode.
  always_comb begin
    next_s        = state_r;
    ready_s       = 2'b00;
    wrEn_s        = 1'b0;
    rdEn_s        = 1'b0;
    addr_s        = ADDR_TX_SC;
    din_s         = 8'h00;
    accept_s      = 1'b0;
    setOversize_s = 1'b0;
    finishOk_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|Req_Valid) next_s = LOAD;
        else            next_s = IDLE;
      end
      LOAD: begin
        if (abortG_s) begin
          next_s = ABORT;
        end else begin
          ready_s  = grantOneHot_s;
          accept_s = validG_s;
          if (validG_s && lastG_s) begin
            wrEn_s = 1'b1;
            addr_s = ADDR_TX_BUFF;
            din_s  = byteG_s;
            next_s = START;
          end else if (validG_s && (cntNext_s == MAX_CNT)) begin
            // The byte that hits the limit without Last is swallowed, not buffered.
            setOversize_s = 1'b1;
            next_s        = ABORT;
          end else if (validG_s) begin
            wrEn_s = 1'b1;
            addr_s = ADDR_TX_BUFF;
            din_s  = byteG_s;
            next_s = LOAD;
          end else begin
            next_s = LOAD;
          end
        end
      end
      START: begin
        if (abortG_s) begin
          next_s = ABORT;
        end else begin
          wrEn_s = 1'b1;
          din_s  = TX_ENABLE;
          next_s = GAP;
        end
      end
      GAP: begin
        if (abortG_s)                   next_s = ABORT;
        else if (gapCnt_r == GAP_LAST)  next_s = POLL;
        else                            next_s = GAP;
      end
      POLL: begin
        if (abortG_s) begin
          next_s = ABORT;
        end else begin
          rdEn_s = 1'b1;
          next_s = CHECK;
        end
      end
      CHECK: begin
        if (abortG_s) begin
          next_s = ABORT;
        end else if (DataOut[0]) begin
          finishOk_s = 1'b1;
          next_s     = FINISH;
        end else begin
          next_s = GAP;
        end
      end
      ABORT: begin
        wrEn_s = 1'b1;
        din_s  = TX_ABORT_FRAME;
        if (oversize_r) next_s = DRAIN;
        else            next_s = FINISH;
      end
      DRAIN: begin
        ready_s  = grantOneHot_s;
        accept_s = validG_s;
        if (validG_s && lastG_s) next_s = FINISH;
        else                     next_s = DRAIN;
      end
      FINISH: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Scheduler state, arbitration history and registered status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      lastServed_r <= 1'b1;
      oversize_r   <= 1'b0;
      busy_r       <= 1'b0;
      byteCnt_r    <= 8'd0;
      gapCnt_r     <= 8'd0;
      done_r       <= 2'b00;
      err_r        <= 2'b00;
    end else begin
      state_r  <= next_s;
      busy_r   <= (next_s != IDLE);
      done_r   <= 2'b00;
      err_r    <= 2'b00;
      gapCnt_r <= ((state_r == GAP) && (next_s == GAP)) ? gapCnt_r + 8'd1 : 8'd0;
      if (next_s == FINISH) begin
        if (finishOk_s) done_r <= grantOneHot_s;
        else            err_r  <= grantOneHot_s;
      end
      if (setOversize_s) oversize_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (|Req_Valid) grant_r <= (&Req_Valid) ? ~lastServed_r : Req_Valid[1];
        end
        LOAD: begin
          if (accept_s) byteCnt_r <= cntNext_s;
        end
        FINISH: begin
          lastServed_r <= grant_r;
          byteCnt_r    <= 8'd0;
          oversize_r   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign Req_Ready   = ready_s;
  assign Req_Done    = done_r;
  assign Req_Err     = err_r;
  assign Grant       = grant_r;
  assign Busy        = busy_r;
  assign Address     = addr_s;
  assign WriteEnable = wrEn_s;
  assign ReadEnable  = rdEn_s;
  assign DataIn      = din_s;

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Randomized bench for hdlc_tx_scheduler: a frame-level model predicts every HDLC
// write, poll timing and the Done/Err outcome of each frame.
`timescale 1ns/1ps
module tb_hdlc_tx_scheduler;
  localparam int MAX_BYTES = 126;
  localparam int POLL_GAP  = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Req_Valid, Req_Last, Req_Abort, Req_Ready, Req_Done, Req_Err;
  logic [15:0] Req_Data;
  logic        Grant, Busy, WriteEnable, ReadEnable;
  logic [2:0]  Address;
  logic [7:0]  DataIn, DataOut;

  typedef struct packed { logic owner; logic ok; } result_t;

  int          checkCnt = 0;
  int          failCnt = 0;
  logic [8:0]  txQ0[$];
  logic [8:0]  txQ1[$];
  logic [10:0] expWr[$];
  result_t     expRes[$];
  logic [1:0]  acc = 2'b00;
  logic        noGaps = 1'b0;
  logic        modelLast = 1'b1;
  int          pollsBeforeDone = 0;
  int          pollIdx = 0;
  int          readCnt = 0;
  int          wrCnt = 0;
  int          cyc = 0;
  int          lastEvt = 0;
  int          expSpacing = 0;
  logic        enSeen = 1'b0;
  logic        prevPulse = 1'b0;

  hdlc_tx_scheduler #(.MAX_BYTES(MAX_BYTES), .POLL_GAP(POLL_GAP)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Last(Req_Last), .Req_Abort(Req_Abort),
    .Req_Ready(Req_Ready), .Req_Done(Req_Done), .Req_Err(Req_Err),
    .Grant(Grant), .Busy(Busy), .Address(Address),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue a frame for a requester and record what the HDLC side must see for it.
  task automatic sendFrame(input logic owner, input int n, input bit abortInGap, input bit useSeq);
    logic [7:0] b;
    logic       bad;
    for (int i = 0; i < n; i++) begin
      b = useSeq ? 8'(17 * (i + 1)) : 8'($urandom);
      if (owner) txQ1.push_back({(i == n - 1), b});
      else       txQ0.push_back({(i == n - 1), b});
      if ((n <= MAX_BYTES) || (i < MAX_BYTES - 1)) expWr.push_back({3'd1, b});
    end
    bad = (n > MAX_BYTES) || abortInGap;
    if (n <= MAX_BYTES) expWr.push_back({3'd0, 8'h02});
    if (bad)            expWr.push_back({3'd0, 8'h04});
    expRes.push_back('{owner: owner, ok: !bad});
    modelLast = owner;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk);
      if (expRes.size() == 0 && !Busy && txQ0.size() == 0 && txQ1.size() == 0) break;
    end
    checkEq({tag, "_pending"}, 32'(expRes.size()), 32'd0);
    checkEq({tag, "_writes_left"}, 32'(expWr.size()), 32'd0);
    checkEq({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  // Requester drivers: present queued bytes, optionally with random valid gaps.
  initial begin
    Req_Valid = 2'b00;
    Req_Data  = 16'h0000;
    Req_Last  = 2'b00;
    forever begin
      @(posedge Clk);
      #1;
      if (!Rst) begin
        txQ0.delete();
        txQ1.delete();
      end else begin
        if (acc[0] && txQ0.size() > 0) void'(txQ0.pop_front());
        if (acc[1] && txQ1.size() > 0) void'(txQ1.pop_front());
      end
      if (txQ0.size() > 0 && (noGaps || $urandom_range(0, 3) != 0)) begin
        Req_Valid[0] = 1'b1; Req_Data[7:0] = txQ0[0][7:0]; Req_Last[0] = txQ0[0][8];
      end else begin
        Req_Valid[0] = 1'b0; Req_Last[0] = 1'b0;
      end
      if (txQ1.size() > 0 && (noGaps || $urandom_range(0, 3) != 0)) begin
        Req_Valid[1] = 1'b1; Req_Data[15:8] = txQ1[0][7:0]; Req_Last[1] = txQ1[0][8];
      end else begin
        Req_Valid[1] = 1'b0; Req_Last[1] = 1'b0;
      end
    end
  end

  // Monitor plus HDLC status responder, sampled mid-cycle.
  initial begin
    result_t     res;
    logic [1:0]  oh;
    logic [31:0] rnd;
    DataOut = 8'h00;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst) begin
        acc = 2'b00; pollIdx = 0; prevPulse = 1'b0;
      end else begin
        checkEq("we_re_excl", 32'(WriteEnable & ReadEnable), 32'd0);
        if (!WriteEnable && !ReadEnable) checkEq("idle_bus", 32'({Address, DataIn}), 32'd0);
        if (Busy) checkEq("ready_other", 32'(Grant ? Req_Ready[0] : Req_Ready[1]), 32'd0);
        else      checkEq("ready_idle", 32'(Req_Ready), 32'd0);
        if (WriteEnable) begin
          wrCnt++;
          if ({Address, DataIn} == {3'd0, 8'h02}) begin
            enSeen = 1'b1; lastEvt = cyc; expSpacing = POLL_GAP + 1;
          end
          if (expWr.size() == 0) checkEq("write_unexpected", 32'({WriteEnable, Address, DataIn}), 32'd0);
          else                   checkEq("write", 32'({Address, DataIn}), 32'(expWr.pop_front()));
        end
        if (ReadEnable) begin
          readCnt++;
          checkEq("read_addr", 32'(Address), 32'd0);
          checkEq("poll_spacing", 32'(cyc - lastEvt), 32'(expSpacing));
          lastEvt = cyc; expSpacing = POLL_GAP + 2;
          rnd = $urandom;
          DataOut = {rnd[7:1], (pollIdx >= pollsBeforeDone)};
          pollIdx++;
        end
        if (prevPulse) checkEq("busy_fall", 32'(Busy), 32'd0);
        prevPulse = (|Req_Done) || (|Req_Err);
        if (prevPulse) begin
          pollIdx = 0;
          if (expRes.size() == 0) begin
            checkEq("result_unexpected", 32'({Req_Done, Req_Err}), 32'd0);
          end else begin
            res = expRes.pop_front();
            oh  = res.owner ? 2'b10 : 2'b01;
            checkEq("result", 32'({Grant, Req_Done, Req_Err}),
                    32'({res.owner, res.ok ? oh : 2'b00, res.ok ? 2'b00 : oh}));
            if (res.ok) checkEq("done_latency", 32'(cyc - lastEvt), 32'd2);
          end
        end
        acc = Req_Valid & Req_Ready;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic first;
    int   n;
    Rst = 1'b0;
    Req_Abort = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    checkEq("reset_outputs", 32'({Req_Ready, Req_Done, Req_Err, Grant, Busy, Address,
                                  WriteEnable, ReadEnable, DataIn}), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);

    // Tie from reset, then alternating ties.
    noGaps = 1'b1; pollsBeforeDone = 0;
    first = !modelLast;
    sendFrame(first, 2, 0, 0); sendFrame(!first, 3, 0, 0);
    sendFrame(first, 1, 0, 0); sendFrame(!first, 2, 0, 0);
    waitIdle("round_robin");
    noGaps = 1'b0;

    // 0x11,0x22,0x33 with two busy polls; the other requester's abort must be ignored.
    pollsBeforeDone = 2; readCnt = 0; Req_Abort[1] = 1'b1;
    sendFrame(0, 3, 0, 1);
    waitIdle("basic");
    checkEq("basic_polls", 32'(readCnt), 32'd3);
    Req_Abort[1] = 1'b0;

    wrCnt = 0;
    sendFrame(1, 127, 0, 0);
    waitIdle("oversize");
    checkEq("oversize_writes", 32'(wrCnt), 32'd126);

    enSeen = 1'b0; pollsBeforeDone = 3;
    sendFrame(0, 4, 1, 0);
    for (int i = 0; i < 2000 && !enSeen; i++) @(negedge Clk);
    checkEq("abort_start_seen", 32'(enSeen), 32'd1);
    @(posedge Clk); #1; Req_Abort[0] = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checkEq("abort_write", 32'({WriteEnable, Address, DataIn}), 32'({1'b1, 3'd0, 8'h04}));
    @(posedge Clk); #1; Req_Abort[0] = 1'b0;
    waitIdle("abort_gap");

    pollsBeforeDone = 1;
    sendFrame(1, 1, 0, 0);
    waitIdle("one_byte");
    sendFrame(0, MAX_BYTES, 0, 0);
    waitIdle("max_len");

    for (int k = 0; k < 12; k++) begin
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(120, 130)) : int'($urandom_range(1, 8));
      pollsBeforeDone = int'($urandom_range(0, 3));
      sendFrame(1'($urandom_range(0, 1)), n, 0, 0);
      waitIdle("random");
    end

    // Reset while loading, then a tie must again favour requester 0.
    noGaps = 1'b1; wrCnt = 0; pollsBeforeDone = 0;
    sendFrame(0, 20, 0, 0);
    for (int i = 0; i < 2000 && wrCnt < 5; i++) @(negedge Clk);
    @(posedge Clk); #3; Rst = 1'b0; #1;
    checkEq("reset_mid_frame", 32'({Req_Ready, Req_Done, Req_Err, Grant, Busy, Address,
                                    WriteEnable, ReadEnable, DataIn}), 32'd0);
    expWr.delete(); expRes.delete(); modelLast = 1'b1;
    repeat (2) @(posedge Clk);
    #3; Rst = 1'b1;
    @(negedge Clk);
    first = !modelLast;
    sendFrame(first, 3, 0, 0); sendFrame(!first, 2, 0, 0);
    waitIdle("after_reset");
    noGaps = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end
endmodule
